// File: rtl/store_pkg.sv
// Shared types for the store narrowing path: size encodings and the buffered write entry.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Default entry shape for a 32-bit byte address; the top re-declares it for other widths.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        lossy;
    } store_entry_t;

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request and memory-write handshake bundle for the store narrowing unit.
interface store_narrow_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_data;
    logic [1:0]        in_size;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_lossy;

    // The unit sits on the slave side: it consumes requests and drives memory writes.
    modport slave (
        input  in_valid, in_addr, in_data, in_size, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_lossy
    );

    modport master (
        output in_valid, in_addr, in_data, in_size, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_lossy
    );
endinterface

// File: rtl/store_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer; readiness depends only on registered occupancy.
module store_skid_buf #(
    parameter type entry_t = store_pkg::store_entry_t
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   push,
    input  entry_t push_entry,
    output logic   can_push,
    output logic   head_valid,
    output entry_t head,
    input  logic   pop_ready
);
    logic [1:0] count_q, count_d;
    entry_t     e0_q, e0_d, e1_q, e1_d;
    logic       do_push;
    logic       do_pop;

    assign can_push   = (count_q != 2'd2);
    assign head_valid = (count_q != 2'd0);
    assign head       = e0_q;
    assign do_push    = push && can_push;
    assign do_pop     = head_valid && pop_ready;

    // Next-state: e0 is always the head, e1 the second-oldest entry.
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d = push_entry;
                end else begin
                    e1_d = push_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry (full blocks push): new entry becomes head.
                e0_d = push_entry;
            end
            default: ;
        endcase
    end

    // State registers; reset discards both entries.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrows a register store into a word-aligned, lane-replicated memory write with byte enables.
// Illegal (misaligned or size 11) requests are consumed and reported instead of written.
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    store_narrow_unit_if.slave   bus,
    input  logic                 clear_err,
    output logic                 err_misaligned,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        logic              lossy;
    } entry_t;

    size_e          size;
    logic [1:0]     lane;
    logic           legal;
    entry_t         entry;
    entry_t         head;
    logic           can_push;
    logic           head_valid;
    logic           accept;
    logic           err_event;
    logic                 err_pulse_q;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    assign size = size_e'(bus.in_size);
    assign lane = bus.in_addr[1:0];

    // Legality check and narrowing of the incoming request.
    always_comb begin
        legal       = 1'b0;
        entry.addr  = {bus.in_addr[ADDR_W-1:2], 2'b00};
        entry.wdata = '0;
        entry.be    = 4'b0000;
        entry.lossy = 1'b0;
        case (size)
            SZ_BYTE: begin
                legal       = 1'b1;
                entry.be    = 4'b0001 << lane;
                entry.wdata = {4{bus.in_data[7:0]}};
                entry.lossy = bus.in_data[31:8] != {24{bus.in_data[7]}};
            end
            SZ_HALF: begin
                legal       = !lane[0];
                entry.be    = lane[1] ? 4'b1100 : 4'b0011;
                entry.wdata = {2{bus.in_data[15:0]}};
                entry.lossy = bus.in_data[31:16] != {16{bus.in_data[15]}};
            end
            SZ_WORD: begin
                legal       = (lane == 2'b00);
                entry.be    = 4'b1111;
                entry.wdata = bus.in_data;
            end
            default: legal = 1'b0;
        endcase
    end

    assign bus.in_ready = can_push;
    assign accept       = bus.in_valid && can_push;
    assign err_event    = accept && !legal;

    store_skid_buf #(
        .entry_t (entry_t)
    ) u_buf (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .push       (accept && legal),
        .push_entry (entry),
        .can_push   (can_push),
        .head_valid (head_valid),
        .head       (head),
        .pop_ready  (bus.mem_ready)
    );

    assign bus.mem_valid = head_valid;
    assign bus.mem_addr  = head.addr;
    assign bus.mem_wdata = head.wdata;
    assign bus.mem_be    = head.be;
    assign bus.mem_lossy = head.lossy;

    // Error counter next-state: clear wins over a same-cycle increment; saturates at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_err) begin
            err_count_d = '0;
        end else if (err_event && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    // Error pulse and counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_event;
            err_count_q <= err_count_d;
        end
    end

    assign err_misaligned = err_pulse_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: driver pushes expected writes, monitor pops and compares.
module tb_store_narrow_unit;
    import store_pkg::*;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ERR_CNT_W = 8;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 clear_err = 1'b0;
    logic                 err_misaligned;
    logic [ERR_CNT_W-1:0] err_count;

    store_narrow_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_narrow_unit #(
        .ADDR_W    (ADDR_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .bus            (bus),
        .clear_err      (clear_err),
        .err_misaligned (err_misaligned),
        .err_count      (err_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        lossy;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_pulse = 1'b0;
    int   exp_count = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, expv, $time);
        end
    endtask

    // Reference: store of 2^size bytes is legal when the address is a multiple of that size.
    function automatic void ref_model(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [1:0] size, output bit legal, output exp_t e);
        int nb;
        int a;
        a       = int'(addr[1:0]);
        legal   = 1'b0;
        e.addr  = addr & ~32'd3;
        e.wdata = '0;
        e.be    = '0;
        e.lossy = 1'b0;
        if (size == 2'd3) return;
        nb = 1 << size;
        if ((a % nb) != 0) return;
        legal = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.wdata[8*i+:8] = data[8*(i%nb)+:8];
            if (i >= a && i < a + nb) e.be[i] = 1'b1;
        end
        if (nb == 1) e.lossy = (32'($signed(data[7:0])) != data);
        else if (nb == 2) e.lossy = (32'($signed(data[15:0])) != data);
    endfunction

    // Monitor: checks handshake state and pops the scoreboard on each transfer.
    always @(negedge Clk) begin
        if (mon_en && Reset_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(sbq.size() < 2));
            chk("mem_valid", 32'(bus.mem_valid), 32'(sbq.size() != 0));
            if (bus.mem_valid && sbq.size() != 0) begin
                chk("mem_addr", bus.mem_addr, sbq[0].addr);
                chk("mem_wdata", bus.mem_wdata, sbq[0].wdata);
                chk("mem_be", 32'(bus.mem_be), 32'(sbq[0].be));
                chk("mem_lossy", 32'(bus.mem_lossy), 32'(sbq[0].lossy));
                if (bus.mem_ready) void'(sbq.pop_front());
            end
            chk("err_pulse", 32'(err_misaligned), 32'(exp_pulse));
            chk("err_count", 32'(err_count), 32'(exp_count));
        end
    end

    // One clock of stimulus; records what the unit should do with it.
    task automatic cycle(input bit v, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input bit mrdy, input bit clr, output bit acc);
        bit   legal;
        exp_t e;
        @(posedge Clk);
        #1;
        bus.in_valid  = v;
        bus.in_addr   = addr;
        bus.in_data   = data;
        bus.in_size   = size;
        bus.mem_ready = mrdy;
        clear_err     = clr;
        @(negedge Clk);
        #1;
        acc = v && bus.in_ready;
        ref_model(addr, data, size, legal, e);
        if (acc && legal) sbq.push_back(e);
        exp_pulse = acc && !legal;
        if (clr) exp_count = 0;
        else if (acc && !legal && exp_count < 255) exp_count++;
    endtask

    task automatic idle(input bit mrdy);
        bit acc;
        cycle(1'b0, 32'h0, 32'h0, 2'b00, mrdy, 1'b0, acc);
    endtask

    initial begin
        bit          acc;
        int          n;
        logic [31:0] addr, data;
        logic [31:0] bp_addr[3];

        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_size   = '0;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_lossy", 32'(bus.mem_lossy), 32'd0);
        chk("rst_err_pulse", 32'(err_misaligned), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        mon_en  = 1'b1;

        // Byte store with sign-extension-equivalent value.
        cycle(1'b1, 32'h1003, 32'hFFFF_FF80, SZ_BYTE, 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("tp_byte_addr", bus.mem_addr, 32'h1000);
        chk("tp_byte_be", 32'(bus.mem_be), 32'b1000);
        chk("tp_byte_wdata", bus.mem_wdata, 32'h8080_8080);
        chk("tp_byte_lossy", 32'(bus.mem_lossy), 32'd0);

        // Half store that loses information.
        cycle(1'b1, 32'h2002, 32'h0001_8000, SZ_HALF, 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("tp_half_addr", bus.mem_addr, 32'h2000);
        chk("tp_half_be", 32'(bus.mem_be), 32'b1100);
        chk("tp_half_wdata", bus.mem_wdata, 32'h8000_8000);
        chk("tp_half_lossy", 32'(bus.mem_lossy), 32'd1);

        // Misaligned word: error pulse and count, then saturation.
        cycle(1'b1, 32'h3001, 32'h1234_5678, SZ_WORD, 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("tp_word_err_pulse", 32'(err_misaligned), 32'd1);
        chk("tp_word_err_count", 32'(err_count), 32'd1);
        chk("tp_word_no_write", 32'(bus.mem_valid), 32'd0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'h3001, 32'h0, SZ_WORD, 1'b1, 1'b0, acc);
        idle(1'b1);
        chk("tp_saturate", 32'(err_count), 32'd255);

        // Clear coincident with an illegal request.
        cycle(1'b1, 32'h3001, 32'h0, SZ_WORD, 1'b1, 1'b1, acc);
        idle(1'b1);
        chk("tp_clr_pulse", 32'(err_misaligned), 32'd1);
        chk("tp_clr_count", 32'(err_count), 32'd0);

        // Backpressure: only two of three requests fit while memory stalls.
        bp_addr[0] = 32'h4000;
        bp_addr[1] = 32'h4104;
        bp_addr[2] = 32'h4208;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (n < 3) begin
                cycle(1'b1, bp_addr[n], 32'hA000_0000 + n, SZ_WORD, 1'b0, 1'b0, acc);
                if (acc) n++;
            end
        end
        chk("bp_accepts", 32'(n), 32'd2);
        for (int k = 0; k < 10 && n < 3; k++) begin
            cycle(1'b1, bp_addr[n], 32'hA000_0000 + n, SZ_WORD, 1'b1, 1'b0, acc);
            if (acc) n++;
        end
        chk("bp_third_accepted", 32'(n), 32'd3);
        for (int k = 0; k < 10 && sbq.size() != 0; k++) idle(1'b1);
        chk("bp_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset with two entries buffered.
        cycle(1'b1, 32'h5000, 32'h1111_1111, SZ_WORD, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h5004, 32'h2222_2222, SZ_WORD, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
        #2;
        Reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("arst_mem_be", 32'(bus.mem_be), 32'd0);
        sbq.delete();
        exp_pulse = 1'b0;
        exp_count = 0;
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            addr = {16'h0, $urandom_range(0, 16'hFFFF)};
            data = $urandom;
            if ($urandom_range(0, 1) == 0) data = 32'($signed(data[7:0]));
            cycle($urandom_range(0, 3) != 0, addr, data, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
        end
        for (int k = 0; k < 10 && sbq.size() != 0; k++) idle(1'b1);
        chk("final_drained", 32'(sbq.size()), 32'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load path's sign extension: takes a 32-bit register value plus a store size (SB/SH/SW) and byte address, and narrows it to a word-aligned memory write with byte enables and lane-replicated data.
- Sits between the MEM-stage store request and the data memory write port.
- Registered valid/ready on both sides with a 2-entry skid buffer.
- Rejects misaligned or illegal stores with an error pulse and a saturating error counter.
- Flags lossy narrowing, i.e. a value whose sign extension would not reproduce the original.

Parameters:
- ADDR_W, 32, byte-address width.
- ERR_CNT_W, 8, width of the saturating misalignment error counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_addr  in  ADDR_W  byte address.
- in_data  in  32  register value to store.
- in_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- mem_valid  out  1  memory write valid.
- mem_ready  in  1  memory accepts write.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits forced 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_lossy  out  1  narrowed value is not sign-extension-equivalent to in_data.
- err_misaligned  out  1  one-cycle pulse when a request is rejected.
- err_count  out  ERR_CNT_W  saturating count of rejected requests.
- clear_err  in  1  synchronous clear of err_count.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, mem_lossy=0.
  - err_misaligned=0, err_count=0, buffer empty, in_ready=1 after release.
  - Reset mid-transfer discards both buffer entries; there is no replay.
- Acceptance: a request transfers when in_valid && in_ready. in_ready = buffer not full, taken from registered occupancy only, with no combinational path from mem_ready.
- Latency and throughput:
  - An accepted legal request appears on mem_* on the next cycle when the buffer was empty.
  - Sustained throughput is 1 per cycle while mem_ready=1.
- Output handshake:
  - mem_* are held stable while mem_valid && !mem_ready.
  - The entry pops on mem_valid && mem_ready.
  - Buffer is FIFO-ordered. Simultaneous push and pop with 1 entry keeps occupancy at 1.
  - When full (2 entries), in_ready=0.
- Narrowing, with a = in_addr[1:0]:
  - byte: legal for any a. mem_be = 4'b0001<<a. mem_wdata = {4{in_data[7:0]}}. lossy = in_data[31:8] is not all copies of in_data[7].
  - half: legal iff a[0]=0. mem_be = a[1] ? 4'b1100 : 4'b0011. mem_wdata = {2{in_data[15:0]}}. lossy = in_data[31:16] is not all copies of in_data[15].
  - word: legal iff a=00. mem_be=4'b1111, mem_wdata=in_data, lossy=0.
  - size 11: always illegal.
- Illegal request:
  - Accepted (consumes in_ready) but never enters the buffer; no mem_valid results.
  - err_misaligned pulses high the cycle after acceptance.
  - err_count increments by 1, saturating at all-ones.
- clear_err: err_count becomes 0 next cycle. It has priority over a same-cycle increment; the err_misaligned pulse is still emitted.
- mem_lossy is informational only: the write is still performed.
- Buffer full plus an illegal request: in_ready=0, so the request is not accepted, no error, no count.

Decomposition:
- Shared package (store_pkg):
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - Struct/typedef for a buffered entry {addr, wdata, be, lossy}.
- One natural sub-module: store_skid_buf, a 2-entry valid/ready FIFO over the entry type.
- Narrowing and legality checks stay combinational in the top.

Test Plan:
- Byte store, addr=0x1003, data=0xFFFFFF80, mem_ready=1 -> next cycle: mem_addr=0x1000, mem_be=1000, mem_wdata=0x80808080, mem_lossy=0.
- Half store, addr=0x2002, data=0x00018000 -> mem_addr=0x2000, mem_be=1100, mem_wdata=0x80008000, mem_lossy=1.
- Word store, addr=0x3001 -> no mem_valid; err_misaligned pulses once; err_count=1. Repeat 300 times with ERR_CNT_W=8 -> err_count holds 255.
- Backpressure: mem_ready=0, issue 3 legal back-to-back stores:
  - in_ready drops after 2 accepts; mem_* are held stable.
  - Raise mem_ready -> the 3 writes drain in order on consecutive cycles.
- clear_err asserted in the same cycle as an illegal request's count update -> err_count=0 and err_misaligned still pulses.
- Reset_n low while 2 entries are buffered and mem_valid=1 -> outputs drop to 0 immediately, asynchronously; after release in_ready=1 and no stale write appears.
